// File: rtl/tilt_detector_pkg.sv
// game_types: shared tilt FSM state type and default tilt thresholds
package game_types;

    typedef enum logic [2:0] {
        NEUTRAL,
        POS_PEND,
        POS,
        NEG_PEND,
        NEG
    } tilt_state_t;

    localparam logic signed [15:0] TILT_THRESH_ON  = 16'sd100;
    localparam logic signed [15:0] TILT_THRESH_OFF = 16'sd60;

endpackage

// File: rtl/tilt_detector_tilt_axis_filter.sv
// tilt_axis_filter: one-axis debounced hysteretic tilt FSM; TILT_AVG_EN adds a 4-sample moving average
module tilt_axis_filter
    import game_types::*;
#(
    parameter logic signed [15:0] THRESH_ON    = TILT_THRESH_ON,
    parameter logic signed [15:0] THRESH_OFF   = TILT_THRESH_OFF,
    parameter int                 STABLE_COUNT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] sample,
    input  logic               valid,
    input  logic               enable,
    output logic               pos,
    output logic               neg
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic signed [16:0] ON  = {THRESH_ON[15], THRESH_ON};
    localparam logic signed [16:0] OFF = {THRESH_OFF[15], THRESH_OFF};

    if (THRESH_OFF < 0 || THRESH_OFF > THRESH_ON || STABLE_COUNT < 1) begin : g_bad_params
        $error("tilt_axis_filter: need 0 <= THRESH_OFF <= THRESH_ON and STABLE_COUNT >= 1");
    end

    logic signed [15:0] s;
    logic signed [16:0] sx;
    tilt_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pos_q, neg_q, hi, lo;

`ifdef TILT_AVG_EN
    logic signed [15:0] h1_q, h2_q, h3_q;
    logic signed [17:0] sum;

    assign sum = 18'(sample) + 18'(h1_q) + 18'(h2_q) + 18'(h3_q);
    assign s   = sum[17:2];

    // Sample history shifts only on valid samples; tilt_enable does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= '0;
            h2_q <= '0;
            h3_q <= '0;
        end else if (valid) begin
            h1_q <= sample;
            h2_q <= h1_q;
            h3_q <= h2_q;
        end
    end
`else
    assign s = sample;
`endif

    assign sx  = {s[15], s};
    assign hi  = sx > ON;
    assign lo  = sx < -ON;
    assign pos = pos_q;
    assign neg = neg_q;

    // Next state: over-threshold samples build the pending count, in-band samples release or hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = NEUTRAL;
            cnt_d   = '0;
        end else if (valid && hi) begin
            cnt_d   = (state_q == POS_PEND) ? cnt_q + 1'b1 : (state_q == POS) ? cnt_q : CW'(1);
            state_d = (state_q == POS || int'(cnt_d) >= STABLE_COUNT) ? POS : POS_PEND;
        end else if (valid && lo) begin
            cnt_d   = (state_q == NEG_PEND) ? cnt_q + 1'b1 : (state_q == NEG) ? cnt_q : CW'(1);
            state_d = (state_q == NEG || int'(cnt_d) >= STABLE_COUNT) ? NEG : NEG_PEND;
        end else if (valid) begin
            state_d = (state_q == POS && sx >= OFF) ? POS : (state_q == NEG && sx <= -OFF) ? NEG : NEUTRAL;
            cnt_d   = (state_d == NEUTRAL) ? '0 : cnt_q;
        end
    end

    // State, counter and registered direction levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NEUTRAL;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= state_d == POS;
            neg_q   <= state_d == NEG;
        end
    end

endmodule

// File: rtl/tilt_detector.sv
// tilt_detector: maps X/Y accelerometer samples to debounced left/right/up/down levels (optional TILT_AVG_EN averaging)
module tilt_detector
    import game_types::*;
#(
    parameter logic signed [15:0] THRESH_ON    = TILT_THRESH_ON,
    parameter logic signed [15:0] THRESH_OFF   = TILT_THRESH_OFF,
    parameter int                 STABLE_COUNT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] accel_x,
    input  logic signed [15:0] accel_y,
    input  logic               accel_valid,
    input  logic               tilt_enable,
    output logic               left_tilt,
    output logic               right_tilt,
    output logic               up_tilt,
    output logic               down_tilt
);

    tilt_axis_filter #(
        .THRESH_ON   (THRESH_ON),
        .THRESH_OFF  (THRESH_OFF),
        .STABLE_COUNT(STABLE_COUNT)
    ) u_x (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(accel_x),
        .valid (accel_valid),
        .enable(tilt_enable),
        .pos   (right_tilt),
        .neg   (left_tilt)
    );

    tilt_axis_filter #(
        .THRESH_ON   (THRESH_ON),
        .THRESH_OFF  (THRESH_OFF),
        .STABLE_COUNT(STABLE_COUNT)
    ) u_y (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(accel_y),
        .valid (accel_valid),
        .enable(tilt_enable),
        .pos   (down_tilt),
        .neg   (up_tilt)
    );

endmodule

// File: tb/tb_tilt_detector.sv
// tb_tilt_detector: directed self-checking bench for tilt_detector
module tb_tilt_detector;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] accel_x = '0;
    logic signed [15:0] accel_y = '0;
    logic               accel_valid = 1'b0;
    logic               tilt_enable = 1'b1;
    logic               left_tilt, right_tilt, up_tilt, down_tilt;
    logic [3:0]         dirs;
    int                 total = 0;
    int                 bad = 0;

    assign dirs = {left_tilt, right_tilt, up_tilt, down_tilt};

    always #5 clk = ~clk;

    tilt_detector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_valid(accel_valid),
        .tilt_enable(tilt_enable),
        .left_tilt  (left_tilt),
        .right_tilt (right_tilt),
        .up_tilt    (up_tilt),
        .down_tilt  (down_tilt)
    );

    // Called at a negedge; drives one strobe and returns at the next negedge, after the sampling edge
    task automatic strobe(input logic signed [15:0] x, input logic signed [15:0] y);
        accel_x = x;
        accel_y = y;
        accel_valid = 1'b1;
        @(negedge clk);
        accel_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        accel_x = 16'sd200;
        accel_valid = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL reset_hold: got %b want %b", dirs, 4'b0000); end
        accel_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            strobe(16'sd200, 16'sd0);
            total++;
            if (dirs !== (i == 3 ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL reset_then_right[%0d]: got %b want %b", i, dirs, (i == 3 ? 4'b0100 : 4'b0000)); end
        end
    endtask

    task automatic test_hysteresis;
        strobe(16'sd80, 16'sd0);
        total++;
        if (dirs !== 4'b0100) begin bad++; $display("FAIL hyst_80: got %b want %b", dirs, 4'b0100); end
        strobe(16'sd60, 16'sd0);
        total++;
        if (dirs !== 4'b0100) begin bad++; $display("FAIL hyst_60: got %b want %b", dirs, 4'b0100); end
        strobe(16'sd59, 16'sd0);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL hyst_59: got %b want %b", dirs, 4'b0000); end
        for (int i = 0; i < 5; i++) begin
            strobe(16'sd100, 16'sd0);
            total++;
            if (dirs !== 4'b0000) begin bad++; $display("FAIL hyst_100[%0d]: got %b want %b", i, dirs, 4'b0000); end
        end
    endtask

    task automatic test_debounce;
        logic signed [15:0] seq [5] = '{16'sd150, 16'sd150, 16'sd0, 16'sd150, 16'sd150};
        for (int i = 0; i < 5; i++) begin
            strobe(seq[i], 16'sd0);
            total++;
            if (dirs !== 4'b0000) begin bad++; $display("FAIL debounce_gap[%0d]: got %b want %b", i, dirs, 4'b0000); end
        end
        strobe(16'sd0, 16'sd0);
        strobe(16'sd150, 16'sd0);
        for (int i = 1; i <= 3; i++) begin
            strobe(-16'sd150, 16'sd0);
            total++;
            if (dirs !== (i == 3 ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL debounce_left[%0d]: got %b want %b", i, dirs, (i == 3 ? 4'b1000 : 4'b0000)); end
        end
    endtask

    task automatic test_reversal;
        for (int i = 1; i <= 3; i++) strobe(16'sd200, 16'sd0);
        total++;
        if (dirs !== 4'b0100) begin bad++; $display("FAIL rev_right: got %b want %b", dirs, 4'b0100); end
        for (int i = 1; i <= 3; i++) begin
            strobe(-16'sd32768, 16'sd0);
            total++;
            if (dirs !== (i == 3 ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL rev_min[%0d]: got %b want %b", i, dirs, (i == 3 ? 4'b1000 : 4'b0000)); end
        end
    endtask

    task automatic test_diagonal;
        for (int i = 1; i <= 3; i++) begin
            strobe(-16'sd200, 16'sd200);
            total++;
            if (dirs !== (i == 3 ? 4'b1001 : 4'b1000)) begin bad++; $display("FAIL diag[%0d]: got %b want %b", i, dirs, (i == 3 ? 4'b1001 : 4'b1000)); end
        end
    endtask

    task automatic test_gating;
        for (int i = 1; i <= 3; i++) strobe(16'sd0, -16'sd200);
        total++;
        if (dirs !== 4'b0010) begin bad++; $display("FAIL gate_up: got %b want %b", dirs, 4'b0010); end
        tilt_enable = 1'b0;
        @(negedge clk);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL gate_off: got %b want %b", dirs, 4'b0000); end
        tilt_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            strobe(16'sd0, -16'sd200);
            total++;
            if (dirs !== (i == 3 ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL gate_reen[%0d]: got %b want %b", i, dirs, (i == 3 ? 4'b0010 : 4'b0000)); end
        end
        tilt_enable = 1'b0;
        strobe(16'sd0, -16'sd200);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL gate_with_valid: got %b want %b", dirs, 4'b0000); end
        tilt_enable = 1'b1;
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 3; i++) strobe(16'sd200, 16'sd0);
        total++;
        if (dirs !== 4'b0100) begin bad++; $display("FAIL arst_pre: got %b want %b", dirs, 4'b0100); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL arst_immediate: got %b want %b", dirs, 4'b0000); end
        @(negedge clk);
        rst_n = 1'b1;
        strobe(16'sd200, 16'sd0);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL arst_restart: got %b want %b", dirs, 4'b0000); end
    endtask

    task automatic test_avg;
        logic signed [15:0] seq [8] = '{16'sd400, 16'sd0, 16'sd0, 16'sd0, 16'sd4, 16'sd404, 16'sd404, 16'sd404};
        for (int i = 0; i < 8; i++) begin
            strobe(seq[i], 16'sd0);
            total++;
            if (dirs !== (i == 7 ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL avg[%0d]: got %b want %b", i, dirs, (i == 7 ? 4'b0100 : 4'b0000)); end
        end
    endtask

    initial begin
        @(negedge clk);
`ifdef TILT_AVG_EN
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (dirs !== 4'b0000) begin bad++; $display("FAIL avg_reset: got %b want %b", dirs, 4'b0000); end
        rst_n = 1'b1;
        @(negedge clk);
        test_avg();
`else
        test_reset();
        test_hysteresis();
        test_debounce();
        test_reversal();
        test_diagonal();
        test_gating();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
